fleet_march_sequencer: RTL
==========================

Name: fleet_march_sequencer

Overview:
Controller for the fleet march square-wave channel. Each fleet movement step from game logic triggers the next tone of a repeating four-note bass cycle. The block drives the period input of the fleet square-wave generator and a tone gate that the audio unit uses to mute the channel between notes. It sits between the fleet movement logic and the audio unit's fleet channel, replacing a free-running fleet period.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz.
NOTE_MS, 100, tone duration per step in ms; NOTE_CYCLES = CLK_FREQ/1000*NOTE_MS; must be >= 1.
PERIOD_0, 1_600_000, square period in clk cycles for note 0.
PERIOD_1, 1_800_000, period for note 1.
PERIOD_2, 2_000_000, period for note 2.
PERIOD_3, 2_200_000, period for note 3. All PERIOD_n are nonzero and fit in 32 bits.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
enable  input  1  sequencer enable; low = silent, note index cleared.
fleet_step  input  1  single-cycle pulse per fleet move.
pause  input  1  freezes note-duration countdown while high; tone held.
period  output  32  square period to the fleet generator; 0 when silent.
tone_on  output  1  high while a note sounds.
note_idx  output  2  index of the current or most recent note.

Behaviour:
- Reset (async assert): state IDLE, period=0, tone_on=0, note_idx=0, next index=0, duration counter=0. All outputs are registered.
- States: IDLE and PLAYING.
- Step accepted: fleet_step=1 and enable=1 at a rising edge, in either state.
- On the next cycle after acceptance: state=PLAYING, tone_on=1, note_idx=next index, period=PERIOD_[next index], counter=NOTE_CYCLES-1, next index increments mod 4 (3->0).
- PLAYING, no step: if pause=0 and counter>0, decrement. If pause=0 and counter==0, go to IDLE next cycle: tone_on=0, period=0, note_idx holds.
- Net effect: without pause or retrigger, tone_on is high for exactly NOTE_CYCLES cycles. Each paused cycle extends that by one.
- Retrigger: a step accepted while PLAYING, including the cycle the counter is 0, restarts the note with the next index. The counter reloads and tone_on stays high with no gap.
- Step with pause in the same cycle: step is accepted and the counter loads; the countdown is frozen from the next cycle while pause stays high.
- enable=0: synchronous clear on the next edge to IDLE, period=0, tone_on=0, note_idx=0, next index=0. fleet_step is ignored. This takes priority over a simultaneous step and over pause.
- pause in IDLE has no effect. fleet_step in IDLE with enable=1 starts a note.
- Reset mid-note: immediate silence, and the sequence restarts at note 0 after release.
- NOTE_CYCLES=1: a single-cycle tone per step.

Test Plan:
Use NOTE_MS and CLK_FREQ chosen so NOTE_CYCLES=5, with PERIOD_0..3 = 10, 20, 30, 40.
1. Reset, then enable=1 with one fleet_step pulse -> next cycle tone_on=1, period=10, note_idx=0. tone_on is high exactly 5 cycles, then period=0, note_idx stays 0.
2. Five steps spaced 10 cycles apart -> periods 10, 20, 30, 40, 10; note_idx 0, 1, 2, 3, 0 (wrap).
3. Step, then a second step 3 cycles later -> tone_on never drops; period goes 10->20; tone_on stays high 5 cycles after the second step.
4. Step, then pause high for 4 cycles starting at cycle 2 -> tone_on high 9 cycles in total, period constant at 10.
5. Mid-note enable=0 together with fleet_step -> next cycle tone_on=0, period=0, note_idx=0. After enable=1 and a step, period=10.
6. Assert rst_n=0 asynchronously mid-note (between edges) -> outputs clear immediately without waiting for a clock edge. After release, the first step plays note 0.

Source files
------------

// File: rtl/fleet_march_if.sv
// Handshake bundle between fleet movement logic, the march sequencer and the
// audio unit's fleet square-wave channel.
interface fleet_march_if;
  logic        enable;
  logic        fleet_step;
  logic        pause;
  logic [31:0] period;
  logic        tone_on;
  logic [1:0]  note_idx;

  modport master (
    output enable,
    output fleet_step,
    output pause,
    input  period,
    input  tone_on,
    input  note_idx
  );

  modport slave (
    input  enable,
    input  fleet_step,
    input  pause,
    output period,
    output tone_on,
    output note_idx
  );
endinterface

// File: rtl/fleet_march_sequencer.sv
// Fleet march bass sequencer: each accepted fleet step plays the next note of a
// four-note cycle for NOTE_CYCLES clocks, driving the square period and tone gate.
module fleet_march_sequencer #(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned NOTE_MS  = 100,
  parameter int unsigned PERIOD_0 = 1_600_000,
  parameter int unsigned PERIOD_1 = 1_800_000,
  parameter int unsigned PERIOD_2 = 2_000_000,
  parameter int unsigned PERIOD_3 = 2_200_000
) (
  input logic          clk,
  input logic          rst_n,
  fleet_march_if.slave fleet
);

  localparam int unsigned NOTE_CYCLES = CLK_FREQ / 32'd1000 * NOTE_MS;
  localparam logic [31:0] NOTE_LOAD   = 32'(NOTE_CYCLES - 32'd1);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PLAYING = 1'b1
  } state_t;

  state_t      state_r, state_s;
  logic [31:0] period_r, period_s;
  logic        tone_on_r, tone_on_s;
  logic [1:0]  note_idx_r, note_idx_s;
  logic [1:0]  next_idx_r, next_idx_s;
  logic [31:0] count_r, count_s;

  function automatic logic [31:0] note_period(input logic [1:0] idx);
    logic [31:0] p;
    case (idx)
      2'd0:    p = 32'(PERIOD_0);
      2'd1:    p = 32'(PERIOD_1);
      2'd2:    p = 32'(PERIOD_2);
      2'd3:    p = 32'(PERIOD_3);
      default: p = 32'(PERIOD_0);
    endcase
    return p;
  endfunction

  // State register and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      period_r   <= 32'd0;
      tone_on_r  <= 1'b0;
      note_idx_r <= 2'd0;
      next_idx_r <= 2'd0;
      count_r    <= 32'd0;
    end else begin
      state_r    <= state_s;
      period_r   <= period_s;
      tone_on_r  <= tone_on_s;
      note_idx_r <= note_idx_s;
      next_idx_r <= next_idx_s;
      count_r    <= count_s;
    end
  end

  // Next-state: disable beats everything, a step always (re)starts a note
  always_comb begin
    state_s    = state_r;
    period_s   = period_r;
    tone_on_s  = tone_on_r;
    note_idx_s = note_idx_r;
    next_idx_s = next_idx_r;
    count_s    = count_r;
    if (!fleet.enable) begin
      state_s    = IDLE;
      period_s   = 32'd0;
      tone_on_s  = 1'b0;
      note_idx_s = 2'd0;
      next_idx_s = 2'd0;
      count_s    = 32'd0;
    end else if (fleet.fleet_step) begin
      state_s    = PLAYING;
      tone_on_s  = 1'b1;
      note_idx_s = next_idx_r;
      period_s   = note_period(next_idx_r);
      count_s    = NOTE_LOAD;
      next_idx_s = next_idx_r + 2'd1;
    end else begin
      case (state_r)
        PLAYING: begin
          if (fleet.pause) begin
            count_s = count_r;
          end else if (count_r != 32'd0) begin
            count_s = count_r - 32'd1;
          end else begin
            state_s   = IDLE;
            tone_on_s = 1'b0;
            period_s  = 32'd0;
          end
        end
        IDLE: begin
          state_s = IDLE;
        end
        default: begin
          state_s   = IDLE;
          tone_on_s = 1'b0;
          period_s  = 32'd0;
        end
      endcase
    end
  end

  assign fleet.period   = period_r;
  assign fleet.tone_on  = tone_on_r;
  assign fleet.note_idx = note_idx_r;

endmodule
